// File: rtl/ibus_sram_if.sv
// ============================================================================
//  Module   : ibus_sram_if
//  Purpose  : Instruction-fetch bus slave in front of a single-port SRAM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ibus_sram_if #(
    parameter int                  C_BUS_SZX     = 5,
    parameter int                  C_BUS_SZ      = 2**C_BUS_SZX,
    parameter int                  C_MEM_DEPTH_X = 10,
    parameter logic [C_BUS_SZ-1:0] C_MEM_BASE    = '0,
    parameter int                  C_WAIT_STATES = 0,
    parameter bit                  C_USER_EXEC   = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clk_en_i,

    output logic                     ireqready_o,
    input  logic                     ireqvalid_i,
    input  logic [1:0]               ireqhpl_i,
    input  logic [C_BUS_SZ-1:0]      ireqaddr_i,

    input  logic                     irspready_i,
    output logic                     irspvalid_o,
    output logic                     irsprerr_o,
    output logic [C_BUS_SZ-1:0]      irspdata_o,

    output logic                     mem_en_o,
    output logic [C_MEM_DEPTH_X-1:0] mem_addr_o,
    input  logic [C_BUS_SZ-1:0]      mem_rdata_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RSP    = 2'd2;

    localparam logic [2:0]        LP_WAIT = 3'(C_WAIT_STATES);
    localparam logic [C_BUS_SZ:0] LP_BASE = {1'b0, C_MEM_BASE};
    // Word index width of the (C_BUS_SZ+1)-bit extended address.
    localparam int                LP_WW   = C_BUS_SZ - 1;

    logic [1:0]          state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                req_err_q, req_err_d;
    logic                rsp_err_q, rsp_err_d;
    logic [C_BUS_SZ-1:0] rsp_data_q, rsp_data_d;

    logic             w_borrow;
    logic [LP_WW-1:0] w_addr_word;
    logic [LP_WW-1:0] w_word_off;
    logic             w_out_of_range;
    logic             w_misalign;
    logic             w_priv_err;
    logic             w_err;
    logic             w_accept;

    // Offset from the base computed with one extra bit: addresses below the
    // base wrap to a value with the top bit set, so they fail the range test.
    assign w_borrow       = (ireqaddr_i[1:0] < LP_BASE[1:0]);
    assign w_addr_word    = {1'b0, ireqaddr_i[C_BUS_SZ-1:2]};
    assign w_word_off     = w_addr_word - LP_BASE[C_BUS_SZ:2] - LP_WW'(w_borrow);
    assign w_out_of_range = |w_word_off[LP_WW-1:C_MEM_DEPTH_X];
    assign w_misalign     = |ireqaddr_i[1:0];
    assign w_priv_err     = !C_USER_EXEC && (ireqhpl_i == 2'b00);
    assign w_err          = w_misalign | w_out_of_range | w_priv_err;

    assign ireqready_o = reset_i
                       | (state_q == S_IDLE)
                       | ((state_q == S_RSP) & irspready_i);
    assign w_accept    = ~reset_i & clk_en_i & ireqready_o & ireqvalid_i;

    assign mem_en_o    = w_accept & ~w_err;
    assign mem_addr_o  = w_word_off[C_MEM_DEPTH_X-1:0];

    assign irspvalid_o = (state_q == S_RSP);
    assign irsprerr_o  = rsp_err_q;
    assign irspdata_o  = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_err_d  = req_err_q;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;

        if (clk_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        state_d = S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Counter still holds its load value only in the first
                    // ACCESS cycle, which is when SRAM read data is valid.
                    if (cnt_q == LP_WAIT) begin
                        rsp_err_d  = req_err_q;
                        rsp_data_d = req_err_q ? '0 : mem_rdata_i;
                    end
                    if (cnt_q == 3'd0) begin
                        state_d = S_RSP;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                S_RSP: begin
                    if (irspready_i) begin
                        state_d = w_accept ? S_ACCESS : S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (w_accept) begin
                cnt_d     = LP_WAIT;
                req_err_d = w_err;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            req_err_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_err_q  <= req_err_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ibus_sram_if.sv
// ============================================================================
//  Module   : tb_ibus_sram_if
//  Purpose  : Directed, table-driven bench for ibus_sram_if (three configs).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ibus_sram_if;

    logic        clk = 1'b0;
    logic        rst, en, vld, rr;
    logic [1:0]  hpl;
    logic [31:0] addr;

    // dut0: W=0, user exec; dut2: W=2; dutu: W=0, no user exec
    logic        rdy0, val0, rerr0, men0;
    logic [31:0] data0, rd0;
    logic [9:0]  maddr0;
    logic        rdy2, val2, rerr2, men2;
    logic [31:0] data2, rd2;
    logic [9:0]  maddr2;
    logic        rdyu, valu, rerru, menu;
    logic [31:0] datau, rdu;
    logic [9:0]  maddru;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ibus_sram_if dut0 (
        .clk_i(clk), .reset_i(rst), .clk_en_i(en),
        .ireqready_o(rdy0), .ireqvalid_i(vld), .ireqhpl_i(hpl), .ireqaddr_i(addr),
        .irspready_i(rr), .irspvalid_o(val0), .irsprerr_o(rerr0), .irspdata_o(data0),
        .mem_en_o(men0), .mem_addr_o(maddr0), .mem_rdata_i(rd0)
    );

    ibus_sram_if #(.C_WAIT_STATES(2)) dut2 (
        .clk_i(clk), .reset_i(rst), .clk_en_i(en),
        .ireqready_o(rdy2), .ireqvalid_i(vld), .ireqhpl_i(hpl), .ireqaddr_i(addr),
        .irspready_i(rr), .irspvalid_o(val2), .irsprerr_o(rerr2), .irspdata_o(data2),
        .mem_en_o(men2), .mem_addr_o(maddr2), .mem_rdata_i(rd2)
    );

    ibus_sram_if #(.C_USER_EXEC(1'b0)) dutu (
        .clk_i(clk), .reset_i(rst), .clk_en_i(en),
        .ireqready_o(rdyu), .ireqvalid_i(vld), .ireqhpl_i(hpl), .ireqaddr_i(addr),
        .irspready_i(rr), .irspvalid_o(valu), .irsprerr_o(rerru), .irspdata_o(datau),
        .mem_en_o(menu), .mem_addr_o(maddru), .mem_rdata_i(rdu)
    );

    function automatic logic [31:0] sram_word(input logic [9:0] a);
        return (a == 10'd1) ? 32'h0000_0013 : (32'hA500_0000 | {22'b0, a});
    endfunction

    // SRAM models: data appears the cycle after the enable and then holds
    always @(posedge clk) if (men0) rd0 <= sram_word(maddr0);
    always @(posedge clk) if (men2) rd2 <= sram_word(maddr2);
    always @(posedge clk) if (menu) rdu <= sram_word(maddru);

    typedef struct {
        logic        rst, en, vld, rr;
        logic [31:0] addr;
        logic        e_rdy, e_men, e_val, e_rerr;
        logic [9:0]  e_maddr;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, e, q, input logic [31:0] a, input logic rdy_in,
                               input logic x_rdy, x_men, input logic [9:0] x_maddr,
                               input logic x_val, x_rerr, input logic [31:0] x_data);
        vec_t t;
        t.rst = r; t.en = e; t.vld = q; t.addr = a; t.rr = rdy_in;
        t.e_rdy = x_rdy; t.e_men = x_men; t.e_maddr = x_maddr;
        t.e_val = x_val; t.e_rerr = x_rerr; t.e_data = x_data;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, e, q, input logic [1:0] h, input logic [31:0] a,
                       input logic rdy_in);
        rst = r; en = e; vld = q; hpl = h; addr = a; rr = rdy_in;
    endtask

    initial begin
        drv(1'b1, 1'b1, 1'b0, 2'b11, 32'h0, 1'b1);

        // ready, mem_en, mem_addr, valid, rerr, data of dut0 per cycle
        tbl.push_back(v(1, 1, 1, 32'h4,        1, 1, 0, 10'h1,   0, 0, 32'h0));
        tbl.push_back(v(0, 1, 1, 32'h4,        1, 1, 1, 10'h1,   0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 0, 0, 10'h0,   0, 0, 32'h0));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 1, 0, 10'h0,   1, 0, 32'h13));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 1, 0, 10'h0,   0, 0, 32'h13));
        tbl.push_back(v(0, 1, 1, 32'h0,        1, 1, 1, 10'h0,   0, 0, 32'h13));
        tbl.push_back(v(0, 1, 1, 32'h4,        1, 0, 0, 10'h1,   0, 0, 32'h13));
        tbl.push_back(v(0, 1, 1, 32'h4,        1, 1, 1, 10'h1,   1, 0, 32'hA500_0000));
        tbl.push_back(v(0, 1, 1, 32'h8,        1, 0, 0, 10'h2,   0, 0, 32'hA500_0000));
        tbl.push_back(v(0, 1, 1, 32'h8,        1, 1, 1, 10'h2,   1, 0, 32'h13));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 0, 0, 10'h0,   0, 0, 32'h13));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 1, 0, 10'h0,   1, 0, 32'hA500_0002));
        tbl.push_back(v(0, 1, 1, 32'h2,        1, 1, 0, 10'h0,   0, 0, 32'hA500_0002));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 0, 0, 10'h0,   0, 0, 32'hA500_0002));
        tbl.push_back(v(0, 1, 1, 32'h1000,     1, 1, 0, 10'h0,   1, 1, 32'h0));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 0, 0, 10'h0,   0, 1, 32'h0));
        tbl.push_back(v(0, 1, 0, 32'h0,        0, 0, 0, 10'h0,   1, 1, 32'h0));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 1, 0, 10'h0,   1, 1, 32'h0));
        tbl.push_back(v(0, 1, 1, 32'hFFFF_FFFC, 1, 1, 0, 10'h3FF, 0, 1, 32'h0));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 0, 0, 10'h0,   0, 1, 32'h0));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 1, 0, 10'h0,   1, 1, 32'h0));
        tbl.push_back(v(0, 0, 1, 32'h4,        1, 1, 0, 10'h1,   0, 1, 32'h0));
        tbl.push_back(v(0, 1, 0, 32'h0,        1, 1, 0, 10'h0,   0, 1, 32'h0));

        foreach (tbl[i]) begin
            tick();
            drv(tbl[i].rst, tbl[i].en, tbl[i].vld, 2'b11, tbl[i].addr, tbl[i].rr);
            #4;
            chk($sformatf("vec%0d", i),
                {18'b0, rdy0, men0, maddr0, val0, rerr0, data0},
                {18'b0, tbl[i].e_rdy, tbl[i].e_men, tbl[i].e_maddr,
                 tbl[i].e_val, tbl[i].e_rerr, tbl[i].e_data});
        end

        // W=2 with fetcher stalling 3 cycles: valid at N+4, held 4 cycles, then IDLE
        tick(); drv(1, 1, 0, 2'b11, 32'h0, 0);
        tick(); drv(0, 1, 1, 2'b11, 32'h4, 0); #4;
        chk("w2_mem_en", {63'b0, men2}, 64'd1);
        chk("w2_mem_addr", {54'b0, maddr2}, 64'd1);
        for (int k = 1; k <= 8; k++) begin
            tick(); drv(0, 1, 0, 2'b11, 32'h0, (k == 7)); #4;
            chk($sformatf("w2_valid_k%0d", k), {63'b0, val2}, {63'b0, (k >= 4 && k <= 7)});
            if (k >= 4 && k <= 7)
                chk($sformatf("w2_data_k%0d", k), {31'b0, rerr2, data2}, 64'h13);
        end
        chk("w2_idle_ready", {63'b0, rdy2}, 64'd1);

        // No user-level execution: hpl 00 faults, hpl 11 fetches
        tick(); drv(1, 1, 0, 2'b11, 32'h0, 1);
        tick(); drv(0, 1, 1, 2'b00, 32'h0, 1); #4;
        chk("ux_user_mem_en", {63'b0, menu}, 64'd0);
        tick(); drv(0, 1, 0, 2'b00, 32'h0, 1); #4;
        chk("ux_user_access_valid", {63'b0, valu}, 64'd0);
        tick(); drv(0, 1, 0, 2'b00, 32'h0, 1); #4;
        chk("ux_user_rsp", {30'b0, valu, rerru, datau}, {30'b0, 1'b1, 1'b1, 32'h0});
        tick(); drv(0, 1, 1, 2'b11, 32'h0, 1); #4;
        chk("ux_mach_mem_en", {63'b0, menu}, 64'd1);
        tick(); drv(0, 1, 0, 2'b11, 32'h0, 1);
        tick(); drv(0, 1, 0, 2'b11, 32'h0, 1); #4;
        chk("ux_mach_rsp", {30'b0, valu, rerru, datau}, {30'b0, 1'b1, 1'b0, 32'hA500_0000});

        // Reset in ACCESS, even with clock enable low, discards the fetch
        tick(); drv(1, 1, 0, 2'b11, 32'h0, 1);
        tick(); drv(0, 1, 1, 2'b11, 32'h4, 1); #4;
        chk("rst_accept", {63'b0, men0}, 64'd1);
        tick(); drv(1, 0, 1, 2'b11, 32'h4, 1); #4;
        chk("rst_cycle", {62'b0, rdy0, men0}, {62'b0, 1'b1, 1'b0});
        tick(); drv(0, 1, 0, 2'b11, 32'h0, 1); #4;
        chk("rst_idle", {29'b0, rdy0, val0, rerr0, data0}, {29'b0, 1'b1, 1'b0, 1'b0, 32'h0});
        tick(); drv(0, 1, 0, 2'b11, 32'h0, 1); #4;
        chk("rst_no_rsp", {63'b0, val0}, 64'd0);

        // Clock enable low 5 cycles in ACCESS: response at N+7 with data intact
        tick(); drv(1, 1, 0, 2'b11, 32'h0, 1);
        tick(); drv(0, 1, 1, 2'b11, 32'h4, 1); #4;
        chk("ce_accept", {63'b0, men0}, 64'd1);
        for (int k = 1; k <= 7; k++) begin
            tick(); drv(0, (k >= 6), (k <= 5), 2'b11, 32'h8, 1); #4;
            chk($sformatf("ce_valid_k%0d", k), {63'b0, val0}, {63'b0, (k == 7)});
            if (k <= 5)
                chk($sformatf("ce_frozen_k%0d", k), {62'b0, rdy0, men0}, 64'd0);
        end
        chk("ce_data", {31'b0, rerr0, data0}, 64'h13);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
